// File: rtl/cr_pipe_credit_fifo_if.sv
// rtl/cr_pipe_credit_fifo_if.sv - issue/credit, arrival and head-of-buffer signals of cr_pipe_credit_fifo
interface cr_pipe_credit_fifo_if #(
  parameter int pWidth = 10,
  parameter int pDepth = 4
);
  localparam int LW = $clog2(pDepth + 1);

  logic              Issue;
  logic              CanIssue;
  logic              DVld;
  logic [pWidth-1:0] D;
  logic              QVld;
  logic              QRdy;
  logic [pWidth-1:0] Q;
  logic [LW-1:0]     Level;
  logic              Err;

  // producer/consumer side
  modport master (
    output Issue, DVld, D, QRdy,
    input  CanIssue, QVld, Q, Level, Err
  );

  // buffer side
  modport slave (
    input  Issue, DVld, D, QRdy,
    output CanIssue, QVld, Q, Level, Err
  );
endinterface

// File: rtl/cr_pipe_credit_fifo.sv
// rtl/cr_pipe_credit_fifo.sv - credit-tracked output buffer behind a non-stalling pipe; sticky Err under CR_PIPE_CREDIT_FIFO_ERR_EN
module cr_pipe_credit_fifo #(
  parameter int pWidth = 10,
  parameter int pDepth = 4
) (
  input logic               Clk,
  input logic               Rst_n,
  cr_pipe_credit_fifo_if.slave bus
);
  localparam int CW     = $clog2(pDepth + 1);
  localparam int PW     = (pDepth > 1) ? $clog2(pDepth) : 1;
  localparam int LAST_I = pDepth - 1;
  localparam logic [PW-1:0] LAST_PTR = LAST_I[PW-1:0];
  localparam logic [CW:0]   DEPTH_X  = pDepth[CW:0];
  localparam logic [CW-1:0] DEPTH_C  = pDepth[CW-1:0];

  logic [pWidth-1:0] mem [pDepth];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     inflight;
  logic              can_issue;
  logic              issue_ok;
  logic              rd;
  logic              wr;

  // Credits cover both buffered items and items still travelling in the pipe,
  // so every in-flight item is guaranteed a slot. Registers only feed can_issue.
  always_comb begin
    can_issue = ({1'b0, count} + {1'b0, inflight}) < DEPTH_X;
    issue_ok  = bus.Issue && can_issue;
    rd        = (count != '0) && bus.QRdy;
    wr        = bus.DVld && ((count < DEPTH_C) || rd);
  end

  assign bus.CanIssue = can_issue;
  assign bus.QVld     = (count != '0);
  assign bus.Q        = mem[rd_ptr];
  assign bus.Level    = count;

  // Storage write; cleared on reset so Q reads 0 until the first write
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < pDepth; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[wr_ptr] <= bus.D;
    end
  end

  // Pointers wrap at pDepth-1 so any depth, not only powers of two, works
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous write and read cancel, including when full
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count <= '0;
    end else if (wr && !rd) begin
      count <= count + 1'b1;
    end else if (rd && !wr) begin
      count <= count - 1'b1;
    end
  end

  // In-flight tracking: rejected issues are ignored, unexpected arrivals saturate at 0
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      inflight <= '0;
    end else if (issue_ok && !bus.DVld) begin
      inflight <= inflight + 1'b1;
    end else if (!issue_ok && bus.DVld && (inflight != '0)) begin
      inflight <= inflight - 1'b1;
    end
  end

`ifdef CR_PIPE_CREDIT_FIFO_ERR_EN
  logic err_q;

  // Sticky protocol error: issue without credit, dropped arrival, or arrival with nothing in flight
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      err_q <= 1'b0;
    end else if ((bus.Issue && !can_issue) ||
                 (bus.DVld && !wr) ||
                 (bus.DVld && (inflight == '0))) begin
      err_q <= 1'b1;
    end
  end

  assign bus.Err = err_q;
`else
  assign bus.Err = 1'b0;
`endif
endmodule

// File: tb/tb_cr_pipe_credit_fifo.sv
// tb/tb_cr_pipe_credit_fifo.sv - directed self-checking bench for cr_pipe_credit_fifo
module tb_cr_pipe_credit_fifo;
  logic Clk = 1'b0;
  logic Rst_n;

  always #5 Clk = ~Clk;

  cr_pipe_credit_fifo_if #(.pWidth(10), .pDepth(4)) b4 ();
  cr_pipe_credit_fifo_if #(.pWidth(10), .pDepth(3)) b3 ();

  cr_pipe_credit_fifo #(.pWidth(10), .pDepth(4)) dut4 (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (b4.slave)
  );

  cr_pipe_credit_fifo #(.pWidth(10), .pDepth(3)) dut3 (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (b3.slave)
  );

`ifdef CR_PIPE_CREDIT_FIFO_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  logic [9:0] data4;
  logic [9:0] data3;
  logic [31:0] exp_list [4];
  int exp_rd;
  int nxt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; the upstream pipe is one register between Issue and DVld, so an
  // item issued in cycle c is on DVld in c+1 and at the head (QVld) in c+2.
  task automatic step();
    logic a4;
    logic a3;
    logic [9:0] d4;
    logic [9:0] d3;
    a4 = b4.Issue && b4.CanIssue;
    a3 = b3.Issue && b3.CanIssue;
    d4 = data4;
    d3 = data3;
    @(posedge Clk);
    #1;
    b4.DVld = a4;
    b4.D    = a4 ? d4 : 10'h000;
    b3.DVld = a3;
    b3.D    = a3 ? d3 : 10'h000;
  endtask

  initial begin
    Rst_n = 1'b0;
    b4.Issue = 1'b0; b4.DVld = 1'b0; b4.D = '0; b4.QRdy = 1'b0;
    b3.Issue = 1'b0; b3.DVld = 1'b0; b3.D = '0; b3.QRdy = 1'b0;
    data4 = '0;
    data3 = '0;
    #3;
    check("rst_qvld", 32'(b4.QVld), 32'h0);
    check("rst_q", 32'(b4.Q), 32'h0);
    check("rst_level", 32'(b4.Level), 32'h0);
    check("rst_canissue", 32'(b4.CanIssue), 32'h1);
    check("rst_err", 32'(b4.Err), 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    step();

    // Fill: four issues on consecutive cycles, consumer stalled
    for (int k = 0; k < 4; k++) begin
      b4.Issue = 1'b1;
      data4 = 10'(k + 1);
      step();
    end
    b4.Issue = 1'b0;
    check("fill_canissue_low", 32'(b4.CanIssue), 32'h0);
    check("fill_level3", 32'(b4.Level), 32'h3);
    step();
    check("fill_level4", 32'(b4.Level), 32'h4);
    check("fill_q", 32'(b4.Q), 32'h001);
    check("fill_canissue_full", 32'(b4.CanIssue), 32'h0);

    // Drain: one item per cycle, credit returns right after the first read
    b4.QRdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_q", 32'(b4.Q), 32'(k + 1));
      step();
      check("drain_canissue", 32'(b4.CanIssue), 32'h1);
    end
    b4.QRdy = 1'b0;
    check("drain_level", 32'(b4.Level), 32'h0);
    check("drain_qvld", 32'(b4.QVld), 32'h0);

    // Refill with 0x011..0x014 (pointers have wrapped back to slot 0)
    for (int k = 0; k < 4; k++) begin
      b4.Issue = 1'b1;
      data4 = 10'(32'h11 + k);
      step();
    end
    b4.Issue = 1'b0;
    step();
    check("refill_level", 32'(b4.Level), 32'h4);
    check("refill_q", 32'(b4.Q), 32'h011);

    // Forced issue without credit: ignored, Err (when built in) set and sticky
    b4.Issue = 1'b1;
    check("force_canissue", 32'(b4.CanIssue), 32'h0);
    step();
    b4.Issue = 1'b0;
    check("force_err", 32'(b4.Err), 32'(ERR_EXP));
    check("force_inflight", 32'(dut4.inflight), 32'h0);
    step();
    check("force_err_sticky", 32'(b4.Err), 32'(ERR_EXP));
    check("force_level", 32'(b4.Level), 32'h4);

    // Full with simultaneous read and arrival of 0x3FF
    b4.QRdy = 1'b1;
    b4.DVld = 1'b1;
    b4.D    = 10'h3FF;
    check("fullrw_q_before", 32'(b4.Q), 32'h011);
    step();
    check("fullrw_level", 32'(b4.Level), 32'h4);
    exp_list[0] = 32'h012; exp_list[1] = 32'h013;
    exp_list[2] = 32'h014; exp_list[3] = 32'h3FF;
    for (int k = 0; k < 4; k++) begin
      check("fullrw_q", 32'(b4.Q), exp_list[k]);
      step();
    end
    b4.QRdy = 1'b0;
    check("fullrw_level_end", 32'(b4.Level), 32'h0);
    check("fullrw_qvld_end", 32'(b4.QVld), 32'h0);
    check("fullrw_err", 32'(b4.Err), 32'(ERR_EXP));

    // Streaming on the depth-3 instance: one item per cycle once primed
    b3.QRdy = 1'b1;
    exp_rd = 1;
    nxt = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      b3.Issue = b3.CanIssue;
      data3 = 10'(nxt);
      if (b3.CanIssue) nxt++;
      if (cyc >= 2) check("stream_qvld", 32'(b3.QVld), 32'h1);
      if (b3.QVld) begin
        check("stream_q", 32'(b3.Q), 32'(exp_rd));
        exp_rd++;
      end
      step();
    end
    b3.Issue = 1'b0;
    check("stream_reads", 32'(exp_rd), 32'd19);
    check("stream_err", 32'(b3.Err), 32'h0);

    // Mid-stream reset: bring dut4 to count=3, inflight=1, then reset off-edge
    for (int k = 0; k < 4; k++) begin
      b4.Issue = 1'b1;
      data4 = 10'(32'h21 + k);
      step();
    end
    b4.Issue = 1'b0;
    check("mid_level", 32'(b4.Level), 32'h3);
    check("mid_inflight", 32'(dut4.inflight), 32'h1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("mid_rst_qvld", 32'(b4.QVld), 32'h0);
    check("mid_rst_q", 32'(b4.Q), 32'h0);
    check("mid_rst_level", 32'(b4.Level), 32'h0);
    check("mid_rst_canissue", 32'(b4.CanIssue), 32'h1);
    check("mid_rst_err", 32'(b4.Err), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
